// File: rtl/creg_bank.sv
// creg_bank: bank of NCH compare channels against a shared free-running counter.
//
// Each channel has a shadow register (sh), an active compare register (cr),
// a load-pending flag (lp) and an enable bit (cen). Writes land in the
// shadow register. They are either copied to the active register at once
// (imm = 1) or deferred to the next count_wrap (imm = 0).
// The active register is compared with count every cycle. A rising edge of
// (eq & cen) produces a one-cycle registered match pulse. The pulse sets a
// sticky pend flag, and irq is the registered OR of all pend flags.
//
// There is no valid/ready handshake. Every control input is a single-cycle
// strobe sampled on the rising edge of sys_clk.
//
// Ports:
//   sys_clk     clock, all state changes on the rising edge
//   resetl      asynchronous active-low reset
//   count       counter value compared against every active register
//   count_wrap  one-cycle pulse, counter returned to 0 this cycle
//   din         write data
//   wr          write strobe for channel wsel
//   wsel        write channel select (values >= NCH are ignored)
//   imm         sampled with wr: 1 = load active now, 0 = defer to wrap
//   cen_wr      load the channel-enable mask from cen_din
//   cen_din     channel-enable mask data
//   ack         per-channel pend clear strobes
//   rd          readback request, drives dout_oe
//   rsel        readback channel select (values >= NCH read as 0)
//   dout        active register of channel rsel, combinational
//   dout_oe     tristate drive enable, equals rd
//   match       registered one-cycle match pulses
//   pend        sticky pending flags
//   irq         registered OR of pend
module creg_bank #(
  parameter int WIDTH = 11,
  parameter int NCH   = 4,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic [WIDTH-1:0] count,
  input  logic             count_wrap,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic [SW-1:0]    wsel,
  input  logic             imm,
  input  logic             cen_wr,
  input  logic [NCH-1:0]   cen_din,
  input  logic [NCH-1:0]   ack,
  input  logic             rd,
  input  logic [SW-1:0]    rsel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_oe,
  output logic [NCH-1:0]   match,
  output logic [NCH-1:0]   pend,
  output logic             irq
);

  logic [WIDTH-1:0] sh [NCH];
  logic [WIDTH-1:0] cr [NCH];
  logic [NCH-1:0]   lp;
  logic [NCH-1:0]   cen;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   hit_q;

  // Decode the write select. wsel values >= NCH match no channel, so such
  // writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr && (wsel == SW'(i));
    end
  end

  // Shadow/active register update. A write beats a pending wrap transfer
  // on the same channel: when a write coincides with count_wrap, the new
  // data goes straight into the active register. This means the stale
  // shadow value is never made active.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < NCH; i++) begin
        sh[i] <= '0;
        cr[i] <= '0;
      end
      lp <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) begin
          sh[i] <= din;
          if (imm || count_wrap) begin
            cr[i] <= din;
            lp[i] <= 1'b0;
          end else begin
            lp[i] <= 1'b1;
          end
        end else if (count_wrap && lp[i]) begin
          cr[i] <= sh[i];
          lp[i] <= 1'b0;
        end
      end
    end
  end

  // Qualified equality per channel.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = cen[i] && (cr[i] == count);
    end
  end

  // Edge detection against the previous cycle's qualified equality. A new
  // edge can come from count moving onto cr, from cr moving onto a static
  // count, or from cen turning on. pend sets from the registered match
  // pulse, and that set has priority over a same-cycle ack.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      cen   <= '0;
      hit_q <= '0;
      match <= '0;
      pend  <= '0;
      irq   <= 1'b0;
    end else begin
      if (cen_wr) begin
        cen <= cen_din;
      end
      hit_q <= hit;
      match <= hit & ~hit_q;
      pend  <= (pend & ~ack) | match;
      irq   <= |pend;
    end
  end

  // Readback mux. An out-of-range rsel selects nothing and reads as 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rsel == SW'(i)) begin
        dout = cr[i];
      end
    end
  end

  assign dout_oe = rd;

endmodule

// File: tb/tb_creg_bank.sv
// tb_creg_bank: self-checking bench for creg_bank.
// A cycle reference model holds the bank contents as plain arrays. Each
// scenario task drives stimulus and compares the DUT against that model
// and against fixed expected values.
module tb_creg_bank;
  localparam int WIDTH = 11;
  localparam int NCH   = 4;
  localparam int SW    = 2;

  // clock / reset
  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [WIDTH-1:0] count;
  logic             count_wrap;
  logic [WIDTH-1:0] din;
  logic             wr;
  logic [SW-1:0]    wsel;
  logic             imm;
  logic             cen_wr;
  logic [NCH-1:0]   cen_din;
  logic [NCH-1:0]   ack;
  logic             rd;
  logic [SW-1:0]    rsel;
  logic [WIDTH-1:0] dout;
  logic             dout_oe;
  logic [NCH-1:0]   match;
  logic [NCH-1:0]   pend;
  logic             irq;

  creg_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .count(count), .count_wrap(count_wrap),
    .din(din), .wr(wr), .wsel(wsel), .imm(imm), .cen_wr(cen_wr),
    .cen_din(cen_din), .ack(ack), .rd(rd), .rsel(rsel), .dout(dout),
    .dout_oe(dout_oe), .match(match), .pend(pend), .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [WIDTH-1:0] m_sh [NCH];
  logic [WIDTH-1:0] m_cr [NCH];
  logic [NCH-1:0]   m_lp, m_cen, m_prev, m_match, m_pend;
  logic             m_irq;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = '0;
      m_cr[i] = '0;
    end
    m_lp = '0; m_cen = '0; m_prev = '0; m_match = '0; m_pend = '0; m_irq = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] model_dout(input logic [SW-1:0] sel);
    if (int'(sel) < NCH) return m_cr[sel];
    return '0;
  endfunction

  // Advance one clock. The model's next state is computed from the inputs
  // present before the edge. It is committed together with the DUT edge,
  // and the bench then settles 1 time unit past the edge.
  task automatic tick();
    logic [NCH-1:0]   hit, n_lp;
    logic [WIDTH-1:0] n_sh [NCH];
    logic [WIDTH-1:0] n_cr [NCH];
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = m_cen[i] && (m_cr[i] == count);
      n_sh[i] = m_sh[i];
      n_cr[i] = m_cr[i];
      n_lp[i] = m_lp[i];
      if (count_wrap && m_lp[i]) begin
        n_cr[i] = m_sh[i];
        n_lp[i] = 1'b0;
      end
      if (wr && int'(wsel) == i) begin
        n_sh[i] = din;
        if (imm || count_wrap) begin
          n_cr[i] = din;
          n_lp[i] = 1'b0;
        end else begin
          n_lp[i] = 1'b1;
        end
      end
    end
    @(posedge sys_clk);
    m_irq   = |m_pend;
    m_pend  = (m_pend & ~ack) | m_match;
    m_match = hit & ~m_prev;
    m_prev  = hit;
    if (cen_wr) m_cen = cen_din;
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = n_sh[i];
      m_cr[i] = n_cr[i];
    end
    m_lp = n_lp;
    #1;
  endtask

  // driver tasks
  task automatic idle_inputs();
    count_wrap = 0; din = '0; wr = 0; wsel = '0; imm = 0;
    cen_wr = 0; cen_din = '0; ack = '0; rd = 0; rsel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    count = '0;
    resetl = 0;
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    resetl = 1;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_reg(input int sel, input logic [WIDTH-1:0] data, input logic immv);
    wr = 1; wsel = SW'(sel); din = data; imm = immv;
    tick();
    wr = 0; imm = 0;
  endtask

  task automatic set_cen(input logic [NCH-1:0] mask);
    cen_wr = 1; cen_din = mask;
    tick();
    cen_wr = 0;
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    count = '0;
    resetl = 0;
    model_reset();
    #3;
    n_vec++;
    if ({match, pend, irq} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: match=%b pend=%b irq=%b, required all 0", match, pend, irq);
    end
    for (int s = 0; s < NCH; s++) begin
      rsel = SW'(s); rd = s[0];
      #1;
      n_vec++;
      if (dout !== '0 || dout_oe !== rd) begin
        n_err++;
        $display("FAIL reset_dout ch%0d: dout=%h oe=%b, required 0 oe=%b", s, dout, dout_oe, rd);
      end
    end
    rd = 0;
    @(negedge sys_clk);
    resetl = 1;
    // cen is 0 after reset, so count = 0 against cr = 0 must stay silent
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (match !== '0) begin
        n_err++;
        $display("FAIL reset_no_match cyc%0d: match=%b, required 0", c, match);
      end
    end
  endtask

  task automatic test_deferred();
    int pulses = 0;
    int bad_at = -1;
    do_reset();
    count = 1;
    set_cen(4'hF);
    write_reg(1, 11'h123, 1'b0);
    // sweep without a wrap: the deferred value must not become active
    for (int c = 1; c < 2048; c++) begin
      count = WIDTH'(c);
      tick();
      n_vec++;
      if ({match, pend, irq} !== {m_match, m_pend, m_irq} || match[1] !== 1'b0) begin
        n_err++;
        $display("FAIL deferred_pre c=%h: match=%b pend=%b irq=%b, required %b %b %b",
                 c, match, pend, irq, m_match, m_pend, m_irq);
      end
    end
    // wrap, then sweep again. cr[1] still holds 0 during the wrap cycle
    // itself, so the window for the single-pulse check starts at count 1.
    for (int c = 0; c < 2048; c++) begin
      count = WIDTH'(c);
      count_wrap = (c == 0);
      tick();
      count_wrap = 0;
      n_vec++;
      if ({match, pend, irq} !== {m_match, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL deferred_post c=%h: match=%b pend=%b irq=%b, required %b %b %b",
                 c, match, pend, irq, m_match, m_pend, m_irq);
      end
      if (c >= 1 && match[1]) begin
        pulses++;
        if (c != 'h123) bad_at = c;
      end
    end
    n_vec++;
    if (pulses != 1 || bad_at != -1) begin
      n_err++;
      $display("FAIL deferred_pulse: pulses=%0d stray_at=%0d, required 1 pulse at count 0x123", pulses, bad_at);
    end
    rsel = 1; #1;
    n_vec++;
    if (dout !== 11'h123) begin
      n_err++;
      $display("FAIL deferred_cr1: dout=%h, required 123", dout);
    end
  endtask

  task automatic test_immediate();
    int pulses = 0;
    int pend_t = -1;
    int irq_t = -1;
    do_reset();
    count = 5;
    set_cen(4'hF);
    write_reg(0, 11'd5, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (match[0]) pulses++;
      if (pend[0] && pend_t < 0) pend_t = c;
      if (irq && irq_t < 0) irq_t = c;
      n_vec++;
      if ({match, pend, irq} !== {m_match, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL imm_cycle %0d: match=%b pend=%b irq=%b, required %b %b %b",
                 c, match, pend, irq, m_match, m_pend, m_irq);
      end
    end
    n_vec++;
    if (pulses != 1 || pend[0] !== 1'b1 || irq !== 1'b1 || irq_t != pend_t + 1) begin
      n_err++;
      $display("FAIL imm_hold: pulses=%0d pend0=%b irq=%b pend_t=%0d irq_t=%0d, required 1 1 1 irq_t=pend_t+1",
               pulses, pend[0], irq, pend_t, irq_t);
    end
  endtask

  task automatic test_collision();
    do_reset();
    count = 11'h400;
    rsel = 2;
    write_reg(2, 11'h010, 1'b0);
    n_vec++;
    if (dout !== 11'h000) begin
      n_err++;
      $display("FAIL coll_deferred: dout=%h, required 000", dout);
    end
    count_wrap = 1;
    write_reg(2, 11'h020, 1'b0);
    count_wrap = 0;
    n_vec++;
    if (dout !== 11'h020 || dout !== model_dout(2)) begin
      n_err++;
      $display("FAIL coll_write_wins: dout=%h, required 020", dout);
    end
    // a later wrap must not disturb cr[2]; lp was cleared by the collision
    count_wrap = 1;
    tick();
    count_wrap = 0;
    n_vec++;
    if (dout !== 11'h020) begin
      n_err++;
      $display("FAIL coll_second_wrap: dout=%h, required 020", dout);
    end
  endtask

  task automatic test_ack();
    do_reset();
    count = 9;
    write_reg(3, 11'd9, 1'b1);
    set_cen(4'h8);
    tick();
    n_vec++;
    if (match !== 4'h8) begin
      n_err++;
      $display("FAIL ack_match: match=%b, required 1000", match);
    end
    ack = 4'h8;
    tick();
    n_vec++;
    if (pend !== 4'h8 || pend !== m_pend) begin
      n_err++;
      $display("FAIL ack_collision: pend=%b, required 1000", pend);
    end
    tick();
    ack = 4'h0;
    n_vec++;
    if (pend !== 4'h0 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL ack_clear: pend=%b irq=%b, required 0000 1", pend, irq);
    end
    tick();
    n_vec++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      n_err++;
      $display("FAIL ack_irq_drop: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_mask();
    do_reset();
    count = 3;
    for (int i = 0; i < NCH; i++) write_reg(i, 11'd7, 1'b1);
    count = 7;
    set_cen(4'b0101);
    tick();
    n_vec++;
    if (match !== 4'b0101 || match !== m_match) begin
      n_err++;
      $display("FAIL mask_match: match=%b, required 0101", match);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_cen(4'hF);
    write_reg(1, 11'h050, 1'b1);
    write_reg(2, 11'h060, 1'b0);
    for (int c = 'h48; c < 'h58; c++) begin
      count = WIDTH'(c);
      tick();
    end
    n_vec++;
    if (pend[1] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_setup: pend=%b, required pend[1]=1", pend);
    end
    #2;
    resetl = 0;
    model_reset();
    #1;
    rsel = 1;
    #1;
    n_vec++;
    if ({match, pend, irq} !== '0 || dout !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: match=%b pend=%b irq=%b dout=%h, required all 0",
               match, pend, irq, dout);
    end
    count = 0;
    @(negedge sys_clk);
    resetl = 1;
    for (int c = 0; c < 5; c++) begin
      count_wrap = (c == 1);
      tick();
      count_wrap = 0;
      n_vec++;
      if (match !== '0 || {match, pend, irq} !== {m_match, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL arst_release cyc%0d: match=%b pend=%b irq=%b, required 0", c, match, pend, irq);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      count      = WIDTH'($urandom_range(0, 15));
      count_wrap = ($urandom_range(0, 9) == 0);
      wr         = ($urandom_range(0, 4) == 0);
      wsel       = SW'($urandom_range(0, NCH - 1));
      imm        = $urandom_range(0, 1);
      din        = WIDTH'($urandom_range(0, 15));
      cen_wr     = ($urandom_range(0, 9) == 0);
      cen_din    = NCH'($urandom_range(0, (1 << NCH) - 1));
      ack        = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
      rd         = $urandom_range(0, 1);
      rsel       = SW'($urandom_range(0, NCH - 1));
      #1;
      n_vec++;
      if (dout !== model_dout(rsel) || dout_oe !== rd) begin
        n_err++;
        $display("FAIL rand_dout c=%0d: dout=%h oe=%b, required %h %b", c, dout, dout_oe, model_dout(rsel), rd);
      end
      tick();
      n_vec++;
      if ({match, pend, irq} !== {m_match, m_pend, m_irq}) begin
        n_err++;
        $display("FAIL rand_flags c=%0d: match=%b pend=%b irq=%b, required %b %b %b",
                 c, match, pend, irq, m_match, m_pend, m_irq);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_deferred();
    test_immediate();
    test_collision();
    test_ack();
    test_mask();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/creg_bank.md
CREG_BANK -- requirements
Module: creg_bank

Interface
REQ-001 Parameter: WIDTH, 11, compare/count width in bits (2..16).
REQ-002 Parameter: NCH, 4, number of compare channels (1..8); SW = max(1, clog2(NCH)).
REQ-003 Port: sys_clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: resetl  in  1  reset, asynchronous and active-low.
REQ-005 Port: count  in  WIDTH  free-running counter value to compare against.
REQ-006 Port: count_wrap  in  1  one-cycle pulse, counter returned to 0 this cycle.
REQ-007 Port: din  in  WIDTH  write data.
REQ-008 Port: wr  in  1  write strobe to the shadow register of channel wsel.
REQ-009 Port: wsel  in  SW  write channel select.
REQ-010 Port: imm  in  1  sampled with wr; 1 = immediate load into the active register, 0 = deferred to the next count_wrap.
REQ-011 Port: cen_wr  in  1  strobe; loads the channel-enable mask from cen_din.
REQ-012 Port: cen_din  in  NCH  channel-enable mask data.
REQ-013 Port: ack  in  NCH  per-channel pending-clear mask, one-cycle strobe.
REQ-014 Port: rd  in  1  readback request.
REQ-015 Port: rsel  in  SW  readback channel select.
REQ-016 Port: dout  out  WIDTH  active register of channel rsel, combinational.
REQ-017 Port: dout_oe  out  1  equals rd, combinational (tristate drive enable).
REQ-018 Port: match  out  NCH  registered one-cycle match pulses.
REQ-019 Port: pend  out  NCH  sticky pending flags.
REQ-020 Port: irq  out  1  OR of pend, registered.

Function
REQ-021 Each channel SHALL hold a shadow register sh[i], an active register cr[i], a load-pending flag lp[i] and an enable bit cen[i].
REQ-022 wr with wsel = i, imm = 0: sh[i] <= din and lp[i] <= 1.
REQ-023 wr with wsel = i, imm = 1: sh[i] <= din, cr[i] <= din, lp[i] <= 0.
REQ-024 wr with wsel >= NCH: no effect.
REQ-025 On count_wrap, every channel with lp = 1: cr <= sh, lp <= 0.
REQ-026 wr to channel i in the same cycle as count_wrap: sh[i] and cr[i] both load din and lp[i] is cleared, regardless of imm (the write wins; the old shadow value is never transferred).
REQ-027 eq[i] = (cr[i] == count) across all WIDTH bits, combinational.
REQ-028 Match is edge-qualified: match[i] = 1 for one cycle on the clock edge after the first cycle in which eq[i] & cen[i] holds, provided the previous cycle's eq[i] & cen[i] was 0. Latency is 1 cycle.
REQ-029 count held constant at cr[i] SHALL produce exactly one match pulse.
REQ-030 A cr[i] change that makes eq true with count unchanged counts as a new edge and pulses once.
REQ-031 match[i] SHALL set pend[i]; ack[i] clears pend[i].
REQ-032 If match[i] and ack[i] occur in the same cycle, set wins and pend[i] stays 1.
REQ-033 irq <= |pend. irq lags pend by 1 cycle.
REQ-034 cen_wr loads cen; a channel with cen[i] = 0 never pulses and keeps its current pend.
REQ-035 A readback with rsel >= NCH returns dout = 0.

Reset
REQ-036 While resetl = 0 (asynchronous): all sh, cr, lp, cen, the previous-eq history, match, pend and irq SHALL be 0. dout then reflects cr = 0 and dout_oe follows rd.
REQ-037 With cen = 0 after reset, count = 0 SHALL NOT produce any match.
REQ-038 Reset asserted mid-operation discards any deferred loads in progress; no pulse is generated on release until a new rising eq & cen.

Verification
REQ-039 Deferred load: wr ch1 din = 0x123, imm = 0; cen = 0xF; count sweeps 0..0x7FF -> no match[1] before count_wrap; after the wrap, cr[1] = 0x123 and match[1] pulses exactly once, one cycle after count = 0x123.
REQ-040 Immediate load and hold: wr ch0 din = 5, imm = 1, count held at 5 for 10 cycles -> a single match[0] pulse, pend[0] = 1, then irq = 1 one cycle later.
REQ-041 Write/wrap collision: ch2 has lp = 1 with sh = 0x010; wr ch2 din = 0x020 in the same cycle as count_wrap -> cr[2] = 0x020, lp[2] = 0, and 0x010 is never active.
REQ-042 Ack collision: ack[3] asserted in the same cycle as match[3] -> pend[3] stays 1; a lone ack[3] in the next cycle -> pend[3] = 0, and irq drops one cycle later if no other pend bit is set.
REQ-043 Enable mask: cen = 0b0101, all cr = 7, count = 7 -> match = 0b0101 only.
REQ-044 Async reset mid-sweep: pull resetl low between clock edges -> match, pend and irq are 0 immediately; after release with count = 0, no match occurs.
